// File: rtl/csr_hpm_cnt.sv
// Bank of hardware performance counters with CSR-style half-word write/read access,
// per-counter inhibit, superscalar increments and sticky wrap flags.
module csr_hpm_cnt #(
    parameter  int unsigned        NUM_CNT    = 4,
    parameter  int unsigned        CNT_W      = 64,
    parameter  int unsigned        INC_W      = 2,
    parameter  logic [CNT_W-1:0]   INIT_VALUE = '0,
    parameter  logic [11:0]        ADDR       = 12'h000,
    localparam int unsigned        RSZ        = 32
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [1:0]               mode,
    input  logic                     csr_wr,
    input  logic                     wr_hi,
    input  logic [4:0]               wr_sel,
    input  logic [RSZ-1:0]           newCSR,
    input  logic [NUM_CNT-1:0]       inhibit,
    input  logic [NUM_CNT*INC_W-1:0] inc,
    input  logic [NUM_CNT-1:0]       ovf_clr,
    input  logic [4:0]               rd_sel,
    output logic [RSZ-1:0]           csr_lo,
    output logic [RSZ-1:0]           csr_hi,
    output logic [NUM_CNT-1:0]       ovf,
    output logic                     wr_err
);

    localparam int unsigned HI_W     = CNT_W - RSZ;
    localparam logic [1:0]  MIN_PRIV = ADDR[9:8];

    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [CNT_W:0]     sum   [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q;
    logic [NUM_CNT-1:0] ovf_d;
    logic               wr_err_q;
    logic               wr_err_d;
    logic               wr_ok;
    logic [NUM_CNT-1:0] wr_hit;
    logic [NUM_CNT-1:0] wrap;

    // Write qualification: privilege must reach the CSR's level and index must exist.
    always_comb begin
        wr_ok    = csr_wr && (mode >= MIN_PRIV) && (32'(wr_sel) < NUM_CNT);
        wr_err_d = csr_wr && !wr_ok;
    end

    // Per-counter next value: an accepted write replaces one half and pre-empts counting.
    always_comb begin
        wr_hit = '0;
        wrap   = '0;
        ovf_d  = '0;
        for (int unsigned c = 0; c < NUM_CNT; c++) begin
            sum[c]   = {1'b0, cnt_q[c]} + (CNT_W+1)'(inc[c*INC_W +: INC_W]);
            cnt_d[c] = cnt_q[c];
            wr_hit[c] = wr_ok && (wr_sel == 5'(c));
            if (wr_hit[c]) begin
                if (wr_hi) begin
                    cnt_d[c][CNT_W-1:RSZ] = newCSR[HI_W-1:0];
                end else begin
                    cnt_d[c][RSZ-1:0] = newCSR;
                end
            end else if (!inhibit[c]) begin
                cnt_d[c] = sum[c][CNT_W-1:0];
                wrap[c]  = sum[c][CNT_W];
            end
            // A wrap in the same cycle as a clear keeps the flag set.
            ovf_d[c] = wrap[c] | (ovf_q[c] & ~ovf_clr[c]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int unsigned c = 0; c < NUM_CNT; c++) begin
                cnt_q[c] <= INIT_VALUE;
            end
            ovf_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NUM_CNT; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            ovf_q    <= ovf_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Read mux from registered state; indices past the bank read as zero.
    always_comb begin
        csr_lo = '0;
        csr_hi = '0;
        for (int unsigned c = 0; c < NUM_CNT; c++) begin
            if (rd_sel == 5'(c)) begin
                csr_lo = cnt_q[c][RSZ-1:0];
                csr_hi = RSZ'(cnt_q[c][CNT_W-1:RSZ]);
            end
        end
    end

    assign ovf    = ovf_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_csr_hpm_cnt.sv
// Scoreboard bench for csr_hpm_cnt: directed scenarios plus random traffic against a
// behavioural counter model.
module tb_csr_hpm_cnt;

    localparam int unsigned N      = 4;
    localparam logic [11:0] ADDR_P = 12'h300;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic [1:0]    mode;
    logic          csr_wr;
    logic          wr_hi;
    logic [4:0]    wr_sel;
    logic [31:0]   newCSR;
    logic [3:0]    inhibit;
    logic [7:0]    inc;
    logic [3:0]    ovf_clr;
    logic [4:0]    rd_sel;
    logic [31:0]   csr_lo;
    logic [31:0]   csr_hi;
    logic [3:0]    ovf;
    logic          wr_err;

    csr_hpm_cnt #(
        .NUM_CNT    (N),
        .CNT_W      (64),
        .INC_W      (2),
        .INIT_VALUE (64'd0),
        .ADDR       (ADDR_P)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .mode     (mode),
        .csr_wr   (csr_wr),
        .wr_hi    (wr_hi),
        .wr_sel   (wr_sel),
        .newCSR   (newCSR),
        .inhibit  (inhibit),
        .inc      (inc),
        .ovf_clr  (ovf_clr),
        .rd_sel   (rd_sel),
        .csr_lo   (csr_lo),
        .csr_hi   (csr_hi),
        .ovf      (ovf),
        .wr_err   (wr_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        bit        rst;
        bit        wr;
        bit        hi;
        bit [4:0]  wsel;
        bit [31:0] data;
        bit [1:0]  md;
        bit [3:0]  inh;
        bit [7:0]  inc;
        bit [3:0]  clr;
        bit [4:0]  rsel;
    } stim_t;

    typedef struct packed {
        bit [31:0] lo;
        bit [31:0] hi;
        bit [3:0]  ovf;
        bit        err;
    } exp_t;

    exp_t      q[$];
    bit [63:0] m_cnt [N];
    bit [3:0]  m_ovf;
    bit        m_err;
    int        errors = 0;
    int        checks = 0;

    function automatic stim_t idle(input bit [4:0] rsel);
        stim_t s;
        s      = '0;
        s.md   = 2'd3;
        s.rsel = rsel;
        return s;
    endfunction

    // Apply one cycle of stimulus and advance the reference model to the post-edge state.
    task automatic step(input stim_t s);
        bit        acc;
        bit [63:0] old;
        bit        wrapped;
        exp_t      e;
        @(negedge clk_in);
        #1;
        reset_in = s.rst;
        csr_wr   = s.wr;
        wr_hi    = s.hi;
        wr_sel   = s.wsel;
        newCSR   = s.data;
        mode     = s.md;
        inhibit  = s.inh;
        inc      = s.inc;
        ovf_clr  = s.clr;
        rd_sel   = s.rsel;
        if (s.rst) begin
            for (int c = 0; c < N; c++) m_cnt[c] = 64'd0;
            m_ovf = 4'd0;
            m_err = 1'b0;
        end else begin
            acc   = s.wr && (s.md >= ADDR_P[9:8]) && (s.wsel < 5'(N));
            m_err = s.wr && !acc;
            for (int c = 0; c < N; c++) begin
                wrapped = 1'b0;
                if (acc && s.wsel == 5'(c)) begin
                    if (s.hi) m_cnt[c][63:32] = s.data;
                    else      m_cnt[c][31:0]  = s.data;
                end else if (!s.inh[c]) begin
                    old      = m_cnt[c];
                    m_cnt[c] = old + 64'(s.inc[2*c +: 2]);
                    wrapped  = m_cnt[c] < old;
                end
                if (wrapped)       m_ovf[c] = 1'b1;
                else if (s.clr[c]) m_ovf[c] = 1'b0;
            end
        end
        e = '0;
        for (int c = 0; c < N; c++) begin
            if (s.rsel == 5'(c)) begin
                e.lo = m_cnt[c][31:0];
                e.hi = m_cnt[c][63:32];
            end
        end
        e.ovf = m_ovf;
        e.err = m_err;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT's state is visible, compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("csr_lo", csr_lo, e.lo);
                check("csr_hi", csr_hi, e.hi);
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("wr_err", 32'(wr_err), 32'(e.err));
            end
        end
    end

    initial begin
        stim_t s;
        reset_in = 1'b1;
        csr_wr   = 1'b0;
        wr_hi    = 1'b0;
        wr_sel   = 5'd0;
        newCSR   = 32'd0;
        mode     = 2'd3;
        inhibit  = 4'd0;
        inc      = 8'd0;
        ovf_clr  = 4'd0;
        rd_sel   = 5'd0;

        s = idle(0); s.rst = 1'b1;
        step(s); step(s);

        // Counter 0 counts by 3 for four cycles
        repeat (4) begin s = idle(0); s.inc = 8'h03; step(s); end

        // Low-half write then a carry into the upper half
        s = idle(1); s.wr = 1'b1; s.wsel = 5'd1; s.data = 32'hFFFF_FFFE; step(s);
        s = idle(1); s.inc = 8'h08; step(s);
        step(idle(1));

        // Full wrap on counter 2, then clear racing a second wrap, then a lone clear
        s = idle(2); s.wr = 1'b1; s.wsel = 5'd2; s.hi = 1'b1; s.data = 32'hFFFF_FFFF; step(s);
        s.hi = 1'b0; step(s);
        s = idle(2); s.inc = 8'h10; step(s);
        step(idle(2));
        s = idle(2); s.wr = 1'b1; s.wsel = 5'd2; s.hi = 1'b1; s.data = 32'hFFFF_FFFF; step(s);
        s.hi = 1'b0; step(s);
        s = idle(2); s.inc = 8'h10; s.clr = 4'b0100; step(s);
        step(idle(2));
        s = idle(2); s.clr = 4'b0100; step(s);

        // Under-privileged write alongside an increment of the same counter
        s = idle(3); s.md = 2'd0; s.wr = 1'b1; s.wsel = 5'd3; s.data = 32'hDEAD_BEEF; s.inc = 8'h40;
        step(s);
        step(idle(3));
        step(idle(3));

        // Inhibited counter, out-of-range write and read
        repeat (5) begin s = idle(0); s.inh = 4'b0001; s.inc = 8'h03; step(s); end
        s = idle(7); s.wr = 1'b1; s.wsel = 5'd7; s.data = 32'h1234_5678; step(s);
        step(idle(7));

        // Reset wins over a concurrent write and increment
        s = idle(1); s.inc = 8'hFF; step(s);
        s = idle(1); s.rst = 1'b1; s.wr = 1'b1; s.wsel = 5'd1; s.data = 32'hAAAA_5555; s.inc = 8'hFF;
        step(s);
        step(idle(1));
        step(idle(0));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            s      = '0;
            s.rst  = ($urandom_range(0, 99) == 0);
            s.wr   = ($urandom_range(0, 2) == 0);
            s.hi   = 1'($urandom);
            s.wsel = 5'($urandom_range(0, 7));
            s.data = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            s.md   = 2'($urandom_range(0, 3));
            s.inh  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            s.inc  = 8'($urandom);
            s.clr  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            s.rsel = 5'($urandom_range(0, 7));
            step(s);
        end

        step(idle(0));
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk_in);
            #2;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_hpm_cnt.md
CSR_HPM_CNT -- requirements
Module: csr_hpm_cnt

Interface
REQ-001 SHALL have parameter NUM_CNT, default 4, number of independent counters (legal range 1..32).
REQ-002 SHALL have parameter CNT_W, default 64, counter width (legal range RSZ+1..2*RSZ).
REQ-003 SHALL have parameter INC_W, default 2, width of each per-cycle increment value (superscalar retire count).
REQ-004 SHALL have parameter INIT_VALUE, default 0, reset value of every counter.
REQ-005 SHALL have parameter ADDR, default 0, CSR address; lowest privilege is ADDR[9:8].
REQ-006 SHALL have port clk_in  input  1  sole clock.
REQ-007 SHALL have port reset_in  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port mode  input  2  current privilege mode.
REQ-009 SHALL have port csr_wr  input  1  write strobe.
REQ-010 SHALL have port wr_hi  input  1  write half select: 0 = low RSZ bits, 1 = upper CNT_W-RSZ bits.
REQ-011 SHALL have port wr_sel  input  5  counter index targeted by the write.
REQ-012 SHALL have port newCSR  input  RSZ  write data.
REQ-013 SHALL have port inhibit  input  NUM_CNT  per-counter count inhibit (mcountinhibit style).
REQ-014 SHALL have port inc  input  NUM_CNT*INC_W  per-counter increment; counter c uses slice [c*INC_W +: INC_W].
REQ-015 SHALL have port ovf_clr  input  NUM_CNT  per-counter overflow-flag clear.
REQ-016 SHALL have port rd_sel  input  5  counter index for read.
REQ-017 SHALL have port csr_lo  output  RSZ  low RSZ bits of counter rd_sel.
REQ-018 SHALL have port csr_hi  output  RSZ  upper bits of counter rd_sel, zero-extended to RSZ.
REQ-019 SHALL have port ovf  output  NUM_CNT  sticky wrap flags.
REQ-020 SHALL have port wr_err  output  1  registered one-cycle pulse flagging a rejected write.

Function
REQ-021 SHALL treat a write as accepted when csr_wr=1, mode >= ADDR[9:8] and wr_sel < NUM_CNT.
REQ-022 SHALL, on an accepted write, replace only the addressed half of counter wr_sel with newCSR (truncated to CNT_W-RSZ bits for the upper half), hold the other half, and suppress that counter's increment in that cycle.
REQ-023 SHALL, for every counter not being written, add the zero-extended inc slice when inhibit[c]=0, and hold when inhibit[c]=1.
REQ-024 SHALL perform the add modulo 2^CNT_W, so the carry out of the low RSZ bits propagates into the upper half in the same cycle.
REQ-025 SHALL set ovf[c] on the cycle after an increment carries out of bit CNT_W-1; writes never set ovf.
REQ-026 SHALL clear ovf[c] on ovf_clr[c]=1, except that a simultaneous wrap SHALL win and leave ovf[c]=1.
REQ-027 SHALL pulse wr_err high for exactly one cycle, on the cycle after csr_wr=1 with mode < ADDR[9:8] or wr_sel >= NUM_CNT; a rejected write SHALL leave every counter counting normally.
REQ-028 SHALL drive csr_lo/csr_hi combinationally from the registered counter state, showing the pre-update value in the cycle of a write or increment.
REQ-029 SHALL drive csr_lo=0 and csr_hi=0 when rd_sel >= NUM_CNT.
REQ-030 SHALL update all counters independently and in parallel every cycle.

Reset
REQ-031 SHALL, with reset_in=1 at a clk_in edge, load every counter with INIT_VALUE and clear ovf and wr_err, and SHALL give reset priority over writes, increments and clears.
REQ-032 SHALL, with reset_in asserted mid-count, discard any write or increment presented in that cycle.

Verification
REQ-033 SHALL cover: counter 0 counting with inc0=3, inhibit=0, for 4 cycles from reset -> csr_lo=12, csr_hi=0.
REQ-034 SHALL cover: counter 1 written low=0xFFFF_FFFE, then inc1=2 -> csr_lo=0, csr_hi=1, ovf[1]=0.
REQ-035 SHALL cover: counter 2 written hi=0xFFFF_FFFF and low=0xFFFF_FFFF, then inc2=1 -> counter=0, ovf[2]=1 next cycle; ovf_clr[2] in the same cycle as a second wrap -> ovf[2] stays 1.
REQ-036 SHALL cover: csr_wr with ADDR=0x300, mode=0, and an inc3=1 in the same cycle -> wr_err=1 for one cycle, counter 3 increments by 1 and the data is not written.
REQ-037 SHALL cover: inhibit[0]=1 with inc0=3 for 5 cycles -> counter 0 unchanged; a write with wr_sel=7 (NUM_CNT=4) -> wr_err pulse, and rd_sel=7 reads 0/0.
REQ-038 SHALL cover: reset_in asserted during a write and an increment -> all counters=INIT_VALUE, ovf=0 and wr_err=0 on the next cycle.
